// File: rtl/sar_adc_pkg.sv
// rtl/sar_adc_pkg.sv - shared FSM encoding and constants for the SAR ADC sequencer
package sar_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STRT = 2'd1,
    ST_WAIT = 2'd2,
    ST_PUSH = 2'd3
  } seq_state_t;

  localparam int START_HOLD    = 2;
  localparam int ADC_WIDTH_DEF = 8;
  localparam int AVG_LOG2_DEF  = 2;
  localparam int ACC_WIDTH     = ADC_WIDTH_DEF + AVG_LOG2_DEF;

  // Summing 2^avg_log2 samples of adc_w bits never needs more than this.
  function automatic int acc_width(input int adc_w, input int avg_log2);
    return adc_w + avg_log2;
  endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// rtl/sar_result_fifo.sv - registered result FIFO with full/empty flags
module sar_result_fifo
  import sar_adc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_rd;
  logic             do_wr;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A write into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sar_adc_sequencer.sv
// rtl/sar_adc_sequencer.sv - periodic SAR conversion initiator with averaging and result FIFO
module sar_adc_sequencer
  import sar_adc_pkg::*;
#(
  parameter int ADC_WIDTH  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int AVG_LOG2   = 2,
  parameter int TIMEOUT    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 start,
  input  logic                 eoc,
  input  logic                 den,
  input  logic [ADC_WIDTH-1:0] adc_din,
  output logic [ADC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 miss,
  output logic                 timeout,
  output logic                 overflow
);
  localparam int AW = acc_width(ADC_WIDTH, AVG_LOG2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = AVG_LOG2 + 1;
  localparam int HW = $clog2(START_HOLD + 1);

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT);
  localparam logic [CW-1:0] SAMP_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);

  seq_state_t           state_q, state_d;
  logic [DIV_WIDTH-1:0] per_q, per_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] per_m1;
  logic                 tick;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        scnt_q, scnt_d;
  logic [TW-1:0]        to_q, to_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 sample;
  logic                 push;
  logic [ADC_WIDTH-1:0] push_data;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Period is latched at each wrap (and while disabled) so a change never cuts an interval short.
  assign per_m1 = (per_q == '0) ? '0 : per_q - DIV_WIDTH'(1);
  assign tick   = en && (cnt_q == per_m1);

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (!en) begin
      cnt_d = '0;
      per_d = period;
    end else if (tick) begin
      cnt_d = '0;
      per_d = period;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

  assign sample = eoc && den;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      scnt_q  <= '0;
      to_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      scnt_q  <= scnt_d;
      to_q    <= to_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    scnt_d  = scnt_q;
    to_d    = to_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!en) begin
          acc_d  = '0;
          scnt_d = '0;
        end
        if (tick) begin
          state_d = ST_STRT;
          to_d    = '0;
          hold_d  = '0;
        end
      end
      ST_STRT: begin
        to_d   = to_q + TW'(1);
        hold_d = hold_q + HW'(1);
        if (hold_q == HOLD_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the timeout cycle still counts.
        if (sample) begin
          acc_d   = acc_q + AW'(adc_din);
          scnt_d  = scnt_q + CW'(1);
          state_d = (scnt_q == SAMP_LAST) ? ST_PUSH : ST_IDLE;
        end else if (to_q == TMO_LAST) begin
          acc_d   = '0;
          scnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      ST_PUSH: begin
        acc_d   = '0;
        scnt_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    start   = 1'b0;
    busy    = 1'b0;
    timeout = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_STRT: begin
        start = 1'b1;
        busy  = 1'b1;
      end
      ST_WAIT: begin
        busy    = 1'b1;
        timeout = !sample && (to_q == TMO_LAST);
      end
      ST_PUSH: begin
        busy = 1'b1;
        push = 1'b1;
      end
    endcase
    miss = tick && busy;
  end

  assign push_data = acc_q[AW-1:AVG_LOG2];
  assign out_valid = !fifo_empty;
  assign overflow  = push && fifo_full && !out_ready;

  sar_result_fifo #(
    .WIDTH (ADC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (push_data),
    .rd_en_i   (out_ready),
    .rd_data_o (out_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// tb/tb_sar_adc_sequencer.sv - directed self-checking bench for sar_adc_sequencer
module tb_sar_adc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, start, eoc, den, out_valid, out_ready, busy, miss, timeout, overflow;
  logic [15:0] period;
  logic [7:0]  adc_din, out_data;

  logic        z_en, z_start, z_out_valid, z_out_ready, z_busy, z_miss, z_timeout, z_overflow;
  logic        z_eoc = 1'b0;
  logic        z_den = 1'b0;
  logic [15:0] z_period;
  logic [7:0]  z_din = 8'h00;
  logic [7:0]  z_next = 8'h51;
  logic [7:0]  z_out_data;
  int          z_cnt = 0;

  int n_run = 0;
  int n_fail = 0;
  int m_cnt, s_cnt, t_cnt, e_n, o_cnt, k;

  sar_adc_sequencer u_dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .start(start),
    .eoc(eoc), .den(den), .adc_din(adc_din), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .miss(miss), .timeout(timeout), .overflow(overflow)
  );

  sar_adc_sequencer #(.AVG_LOG2(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(z_en), .period(z_period), .start(z_start),
    .eoc(z_eoc), .den(z_den), .adc_din(z_din), .out_data(z_out_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .busy(z_busy),
    .miss(z_miss), .timeout(z_timeout), .overflow(z_overflow)
  );

  // Converter model for the pass-through instance: result 4 cycles after start rises.
  always @(negedge clk) begin
    z_eoc = 1'b0;
    z_den = 1'b0;
    if (z_cnt != 0) begin
      z_cnt = z_cnt + 1;
      if (z_cnt == 5) begin
        z_eoc  = 1'b1;
        z_den  = 1'b1;
        z_din  = z_next;
        z_next = z_next + 8'd1;
        z_cnt  = 0;
      end
    end else if (z_start) begin
      z_cnt = 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (start !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check(tag, 32'(start), 32'd1);
  endtask

  task automatic do_conv(input logic [7:0] v, input int lat, input string tag);
    wait_start(tag);
    repeat (lat) step();
    eoc = 1'b1;
    den = 1'b1;
    adc_din = v;
    step();
    eoc = 1'b0;
    den = 1'b0;
    adc_din = 8'h00;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; period = 16'd0; eoc = 1'b0; den = 1'b0;
    adc_din = 8'h00; out_ready = 1'b0;
    z_en = 1'b0; z_period = 16'd20; z_out_ready = 1'b0;
    step();
    step();
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'({miss, timeout, overflow}), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    step();

    // Four-sample average: (0x10+0x20+0x30+0x41)>>2 = 0x28
    period = 16'd40;
    en = 1'b1;
    do_conv(8'h10, 9, "avg_s0");
    do_conv(8'h20, 9, "avg_s1");
    do_conv(8'h30, 9, "avg_s2");
    do_conv(8'h41, 9, "avg_s3");
    check("avg_push_busy", 32'(busy), 32'd1);
    check("avg_valid_early", 32'(out_valid), 32'd0);
    step();
    check("avg_valid", 32'(out_valid), 32'd1);
    check("avg_data", 32'(out_data), 32'h28);

    // Reset while start is high
    wait_start("rst_mid_start");
    rst = 1'b1;
    #1;
    check("rst_mid_start_lo", 32'(start), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    en = 1'b0;
    step();
    rst = 1'b0;
    eoc = 1'b1; den = 1'b1; adc_din = 8'h77;
    step();
    step();
    eoc = 1'b0; den = 1'b0; adc_din = 8'h00;
    repeat (3) step();
    check("rst_no_write", 32'(out_valid), 32'd0);
    check("rst_idle", 32'(busy), 32'd0);

    // period 5, latency 12: ticks at +4 and +9 are dropped
    period = 16'd5;
    en = 1'b1;
    wait_start("miss_start");
    m_cnt = 0;
    s_cnt = 0;
    for (int i = 0; i <= 12; i++) begin
      m_cnt += int'(miss);
      s_cnt += int'(start);
      if (i == 12) begin
        eoc = 1'b1; den = 1'b1; adc_din = 8'hFF;
      end
      step();
    end
    eoc = 1'b0; den = 1'b0; adc_din = 8'h00;
    check("miss_count", 32'(m_cnt), 32'd2);
    check("start_width", 32'(s_cnt), 32'd2);
    check("miss_done_idle", 32'(busy), 32'd0);
    step();
    check("idle_tick_no_miss", 32'(miss), 32'd0);
    step();
    check("restart", 32'(start), 32'd1);

    // No answer: timeout 32 cycles after start rises
    t_cnt = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i < 32) t_cnt += int'(timeout);
    end
    check("tmo_early", 32'(t_cnt), 32'd0);
    check("tmo_pulse", 32'(timeout), 32'd1);
    step();
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_single", 32'(timeout), 32'd0);
    step();
    check("tmo_no_start", 32'(start), 32'd0);
    step();
    check("tmo_restart", 32'(start), 32'd1);

    // Earlier 0xFF sample must have been discarded: (1+2+3+4)>>2 = 2
    do_conv(8'h01, 12, "clr_s0");
    do_conv(8'h02, 12, "clr_s1");
    do_conv(8'h03, 12, "clr_s2");
    do_conv(8'h04, 12, "clr_s3");
    step();
    check("clr_valid", 32'(out_valid), 32'd1);
    check("clr_data", 32'(out_data), 32'h02);

    // Partial average dropped by en=0: (0x10*3+0x14)>>2 = 0x11
    do_conv(8'h80, 12, "en_p0");
    do_conv(8'h80, 12, "en_p1");
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    do_conv(8'h10, 12, "en_s0");
    do_conv(8'h10, 12, "en_s1");
    do_conv(8'h10, 12, "en_s2");
    do_conv(8'h14, 12, "en_s3");
    en = 1'b0;
    step();
    out_ready = 1'b1;
    check("en_head", 32'(out_data), 32'h02);
    step();
    check("en_avg", 32'(out_data), 32'h11);
    step();
    check("en_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Pass-through instance: 5 results into a 4-deep FIFO
    z_en = 1'b1;
    e_n = 0; o_cnt = 0; k = 0;
    while (e_n < 5 && k < 1000) begin
      step();
      k++;
      if (z_eoc) e_n++;
      o_cnt += int'(z_overflow);
    end
    check("z_fill_eocs", 32'(e_n), 32'd5);
    check("z_no_early_ovf", 32'(o_cnt), 32'd0);
    step();
    check("z_ovf_pulse", 32'(z_overflow), 32'd1);
    z_en = 1'b0;
    step();
    check("z_ovf_single", 32'(z_overflow), 32'd0);
    z_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("z_drain_valid", 32'(z_out_valid), 32'd1);
      check("z_drain_data", 32'(z_out_data), 32'(8'h51 + i));
      step();
    end
    check("z_empty", 32'(z_out_valid), 32'd0);
    z_out_ready = 1'b0;

    // Refill to full, then push and pop together
    z_en = 1'b1;
    o_cnt = 0; k = 0;
    while (e_n < 10 && k < 1000) begin
      step();
      k++;
      if (z_eoc) e_n++;
      o_cnt += int'(z_overflow);
    end
    check("z_refill_eocs", 32'(e_n), 32'd10);
    check("z_refill_no_ovf", 32'(o_cnt), 32'd0);
    step();
    z_out_ready = 1'b1;
    #1;
    check("z_pushpop_no_ovf", 32'(z_overflow), 32'd0);
    check("z_pushpop_valid", 32'(z_out_valid), 32'd1);
    step();
    z_out_ready = 1'b0;
    z_en = 1'b0;
    check("z_pushpop_head", 32'(z_out_data), 32'h57);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
